// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI video timing controller.
// Guard-band symbols are the TMDS video guard words muxed in downstream while o_guard is high.
package hdmi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;

    localparam logic [1:0] CTL_VIDEO_PREAMBLE_CH1 = 2'b01;
    localparam logic [1:0] CTL_IDLE               = 2'b00;

    localparam logic [9:0] GUARD_VIDEO_CH0 = 10'b1011001100;
    localparam logic [9:0] GUARD_VIDEO_CH1 = 10'b0100110011;
    localparam logic [9:0] GUARD_VIDEO_CH2 = 10'b1011001100;

endpackage

// File: rtl/video_pos_counter.sv
// Wrapping raster position counter (h, v) with enable and a synchronous
// load of a fixed start position; reset also lands on the start position.
module video_pos_counter #(
    parameter int CW      = 12,
    parameter int H_TOTAL = 1650,
    parameter int V_TOTAL = 750,
    parameter int START_H = 0,
    parameter int START_V = 720
) (
    input  logic          pix_clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          en,
    output logic [CW-1:0] h,
    output logic [CW-1:0] v
);

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_INIT = CW'(START_H);
    localparam logic [CW-1:0] V_INIT = CW'(START_V);

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= H_INIT;
            v <= V_INIT;
        end else if (load) begin
            h <= H_INIT;
            v <= V_INIT;
        end else if (en) begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hdmi_video_timing_ctrl.sv
// HDMI raster timing: sync, DE, preamble/guard control periods and a pixel
// request running PIPE_LAT pixels ahead of DE. All outputs are one register late.
//
//  state | meaning
//  IDLE  | counters parked at (0, V_ACTIVE), outputs at blanking
//  RUN   | raster counting, i_en high
//  DRAIN | i_en dropped; keep counting until the last active line ends
module hdmi_video_timing_ctrl
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit H_POL    = 1'b1,
    parameter bit V_POL    = 1'b1,
    parameter int PIPE_LAT = 2,
    parameter int CW       = 12
) (
    input  logic          i_pix_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    output logic          o_de,
    output logic [1:0]    o_ctrl_ch0,
    output logic [1:0]    o_ctrl_ch1,
    output logic [1:0]    o_ctrl_ch2,
    output logic          o_guard,
    output logic          o_req,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_frame_start,
    output logic          o_busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] HA      = CW'(H_ACTIVE);
    localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] PRE_BEG = CW'(H_TOTAL - PREAMBLE_LEN - GUARD_LEN);
    localparam logic [CW-1:0] GRD_BEG = CW'(H_TOTAL - GUARD_LEN);
    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] VA      = CW'(V_ACTIVE);
    localparam logic [CW-1:0] VA_LAST = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);

    state_t state, state_nxt;

    logic          counting;
    logic          park;
    logic [CW-1:0] h, v, hl, vl;

    logic at_exit;
    logic nla;
    logic de_c, hs_c, vs_c, pre_c, grd_c, req_c, fs_c;

    assign counting = (state != IDLE);
    assign park     = (state == IDLE);
    assign at_exit  = (h == H_LAST) && (v == VA_LAST);

    always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_en) state_nxt = RUN;
            RUN:     if (!i_en) state_nxt = DRAIN;
            DRAIN: begin
                // Exit only after the last active line so a frame is never cut short
                if (at_exit)   state_nxt = i_en ? RUN : IDLE;
                else if (i_en) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    video_pos_counter #(
        .CW(CW), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
        .START_H(0), .START_V(V_ACTIVE)
    ) u_main (
        .pix_clk(i_pix_clk), .rst_n(i_rst_n), .load(park), .en(counting),
        .h(h), .v(v)
    );

    // Lead copy parks PIPE_LAT pixels ahead, so it stays ahead through every wrap
    video_pos_counter #(
        .CW(CW), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
        .START_H(PIPE_LAT), .START_V(V_ACTIVE)
    ) u_lead (
        .pix_clk(i_pix_clk), .rst_n(i_rst_n), .load(park), .en(counting),
        .h(hl), .v(vl)
    );

    always_comb begin
        nla   = (v < VA_LAST) || (v == V_LAST);
        de_c  = counting && (h < HA) && (v < VA);
        hs_c  = counting && (h >= HS_BEG) && (h < HS_END);
        vs_c  = counting && (v >= VS_BEG) && (v < VS_END);
        pre_c = counting && nla && (h >= PRE_BEG) && (h < GRD_BEG);
        grd_c = counting && nla && (h >= GRD_BEG);
        req_c = counting && (hl < HA) && (vl < VA);
        fs_c  = counting && (h == '0) && (v == '0);
    end

    always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_de          <= 1'b0;
            o_ctrl_ch0    <= {~V_POL, ~H_POL};
            o_ctrl_ch1    <= CTL_IDLE;
            o_ctrl_ch2    <= CTL_IDLE;
            o_guard       <= 1'b0;
            o_req         <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_frame_start <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_de          <= de_c;
            o_ctrl_ch0    <= {(vs_c ? V_POL : ~V_POL), (hs_c ? H_POL : ~H_POL)};
            o_ctrl_ch1    <= pre_c ? CTL_VIDEO_PREAMBLE_CH1 : CTL_IDLE;
            o_ctrl_ch2    <= CTL_IDLE;
            o_guard       <= grd_c;
            o_req         <= req_c;
            o_frame_start <= fs_c;
            o_busy        <= counting;
            if (req_c) begin
                o_x <= hl;
                o_y <= vl;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_video_timing_ctrl.sv
// Bench for hdmi_video_timing_ctrl on a small raster (33 x 7, PIPE_LAT 2):
// linear-position raster model compared every cycle, plus literal timing pins.
module tb_hdmi_video_timing_ctrl;

    localparam int HA = 16, HFP = 2, HS = 3, HBP = 12;
    localparam int VA = 4, VFP = 1, VS = 1, VBP = 1;
    localparam int PL = 2, CW = 12;
    localparam bit HP = 1'b1, VP = 1'b1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;
    localparam int IDLE_P = VA * HT;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
    logic de, guard, req, fs, busy;
    logic [1:0] c0, c1, c2;
    logic [CW-1:0] x, y;

    int n_checks = 0, n_err = 0;

    always #5 clk = ~clk;

    hdmi_video_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .H_POL(HP), .V_POL(VP), .PIPE_LAT(PL), .CW(CW)
    ) dut (
        .i_pix_clk(clk), .i_rst_n(rst_n), .i_en(en),
        .o_de(de), .o_ctrl_ch0(c0), .o_ctrl_ch1(c1), .o_ctrl_ch2(c2),
        .o_guard(guard), .o_req(req), .o_x(x), .o_y(y),
        .o_frame_start(fs), .o_busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 running, 2 draining; m_p is the linear raster index v*HT+h
    int m_mode = 0;
    int m_p = IDLE_P;
    logic e_de = 0, e_grd = 0, e_req = 0, e_fs = 0, e_busy = 0;
    logic [1:0] e_c0 = {~VP, ~HP}, e_c1 = 2'b00;
    logic [CW-1:0] e_x = '0, e_y = '0;

    always @(negedge rst_n) begin
        m_mode = 0;
        m_p = IDLE_P;
    end

    always @(posedge clk) begin : model
        int h, v, lp, hl, vl;
        bit cnt, nla, hs_a, vs_a;
        if (!rst_n) begin
            m_mode = 0; m_p = IDLE_P;
            e_de = 0; e_grd = 0; e_req = 0; e_fs = 0; e_busy = 0;
            e_c0 = {~VP, ~HP}; e_c1 = 2'b00; e_x = '0; e_y = '0;
        end else begin
            h = m_p % HT; v = m_p / HT;
            lp = (m_p + PL) % FT; hl = lp % HT; vl = lp / HT;
            cnt = (m_mode != 0);
            nla = (v < VA - 1) || (v == VT - 1);
            hs_a = cnt && h >= HA + HFP && h < HA + HFP + HS;
            vs_a = cnt && v >= VA + VFP && v < VA + VFP + VS;
            e_de = cnt && h < HA && v < VA;
            e_c0 = {(vs_a ? VP : ~VP), (hs_a ? HP : ~HP)};
            e_c1 = (cnt && nla && h >= HT - 10 && h <= HT - 3) ? 2'b01 : 2'b00;
            e_grd = cnt && nla && h >= HT - 2;
            e_req = cnt && hl < HA && vl < VA;
            if (e_req) begin
                e_x = CW'(hl);
                e_y = CW'(vl);
            end
            e_fs = cnt && (m_p == 0);
            e_busy = cnt;
            case (m_mode)
                0: if (en) m_mode = 1;
                1: if (!en) m_mode = 2;
                default: begin
                    if (m_p == IDLE_P - 1) m_mode = en ? 1 : 0;
                    else if (en) m_mode = 1;
                end
            endcase
            if (cnt) m_p = (m_p + 1) % FT;
        end
        #1;
        chk("de", de, e_de);
        chk("ctrl_ch0", c0, e_c0);
        chk("ctrl_ch1", c1, e_c1);
        chk("ctrl_ch2", c2, 2'b00);
        chk("guard", guard, e_grd);
        chk("req", req, e_req);
        chk("x", x, e_x);
        chk("y", y, e_y);
        chk("frame_start", fs, e_fs);
        chk("busy", busy, e_busy);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_fs(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!fs && n < limit);
        chk("frame_start_seen", fs, 1);
    endtask

    // Starts on a frame_start sample; runs one frame, optionally toggling en
    task automatic frame_run(input int drop_at, input int raise_at,
                             output int de_cnt, output int rises);
        logic prev;
        de_cnt = de ? 1 : 0;
        rises = de ? 1 : 0;
        prev = de;
        for (int i = 1; i < FT; i++) begin
            tick();
            if (i == drop_at) en = 1'b0;
            if (i == raise_at) en = 1'b1;
            if (de) de_cnt++;
            if (de && !prev) rises++;
            prev = de;
        end
        tick();
        chk("next_frame_start", fs, 1);
    endtask

    logic hist_de[0:2*FT-1];
    logic hist_grd[0:2*FT-1];
    logic hist_req[0:2*FT-1];
    logic [1:0] hist_c0[0:2*FT-1];
    logic [1:0] hist_c1[0:2*FT-1];
    logic [CW-1:0] hist_x[0:2*FT-1];
    logic [CW-1:0] hist_y[0:2*FT-1];
    logic hist_fs[0:2*FT-1];

    initial begin
        int n, dc, rs;
        repeat (3) @(negedge clk);
        chk("rst_de", de, 0);
        chk("rst_ctrl_ch0", c0, 2'b00);
        chk("rst_busy", busy, 0);
        chk("rst_xy", {x, y}, 0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_busy", busy, 0);

        // Startup latency and two recorded frames
        en = 1'b1;
        wait_fs(400, n);
        chk("first_fs_latency", n, 101);
        for (int i = 0; i < 2 * FT; i++) begin
            if (i > 0) tick();
            hist_de[i] = de; hist_grd[i] = guard; hist_req[i] = req;
            hist_c0[i] = c0; hist_c1[i] = c1; hist_x[i] = x; hist_y[i] = y;
            hist_fs[i] = fs;
        end
        dc = 0; rs = 0;
        for (int i = 0; i < FT; i++) begin
            if (hist_de[i]) dc++;
            if (hist_de[i] && (i == 0 || !hist_de[i-1])) rs++;
        end
        chk("frame_de_cycles", dc, 64);
        chk("frame_de_runs", rs, 4);
        chk("de_line1_start", {hist_de[32], hist_de[33]}, 2'b01);
        chk("de_line3_start", hist_de[99], 1);
        chk("de_vblank", hist_de[132], 0);
        chk("hsync_pulse", {hist_c0[17][0], hist_c0[18][0], hist_c0[19][0],
                            hist_c0[20][0], hist_c0[21][0]}, 5'b01110);
        chk("vsync_line", {hist_c0[160][1], hist_c0[170][1], hist_c0[200][1]}, 3'b010);
        chk("preamble_start", {hist_c1[22], hist_c1[23]}, 4'b0001);
        chk("preamble_end", hist_c1[30], 2'b01);
        chk("guard_window", {hist_grd[30], hist_grd[31], hist_grd[32], hist_grd[33]}, 4'b0110);
        chk("no_preamble_after_last", {hist_c1[122], 1'b0, hist_grd[130]}, 3'b000);
        chk("no_preamble_vfp", hist_c1[188], 2'b00);
        chk("preamble_before_frame", hist_c1[221], 2'b01);
        chk("req_lead", {hist_req[30], hist_req[31]}, 2'b01);
        chk("req_first_xy", {hist_x[31], hist_y[31]}, {12'd0, 12'd1});
        chk("req_last_x", {hist_x[46], hist_req[47], hist_x[47]}, {12'd15, 1'b0, 12'd15});
        chk("req_frame_origin", {hist_req[229], hist_x[229], hist_y[229]}, {1'b1, 24'd0});
        chk("second_fs", hist_fs[FT], 1);

        // Drop en at the start of active line 1: lines 1..3 finish, then idle
        wait_fs(300, n);
        repeat (32) tick();
        en = 1'b0;
        n = 0; dc = 0;
        do begin
            tick();
            if (de) dc++;
            n++;
        end while (busy && n < 400);
        chk("drain_reaches_idle", busy, 0);
        chk("drain_de_cycles", dc, 48);

        en = 1'b1;
        wait_fs(400, n);
        chk("restart_fs_latency", n, 101);
        frame_run(-1, -1, dc, rs);
        chk("restart_de_cycles", dc, 64);
        chk("restart_de_runs", rs, 4);

        // en low then high inside one active frame: nothing lost
        frame_run(40, 45, dc, rs);
        chk("toggle_de_cycles", dc, 64);
        chk("toggle_de_runs", rs, 4);

        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 49) == 0) en = ~en;
        end

        // Asynchronous reset in the middle of an active line
        en = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!de && n < 600);
        chk("de_before_reset", de, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_de", de, 0);
        chk("async_rst_req", req, 0);
        chk("async_rst_ctrl_ch0", c0, 2'b00);
        chk("async_rst_guard", guard, 0);
        chk("async_rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_fs(400, n);
        chk("post_reset_fs_latency", n, 101);

        en = 1'b0;
        repeat (10) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/hdmi_video_timing_ctrl.md
Name: hdmi_video_timing_ctrl

Overview:
- Sequences the HDMI transmit path: generates raster counters, sync, data enable and TMDS control-period values for the three-channel encoder and serializer stage.
- Inserts HDMI video preamble and video leading guard band before every active line.
- Issues a pixel request with x/y coordinates PIPE_LAT cycles ahead of DE, so the upstream fractal pixel pipeline delivers colour aligned to o_de.
- Sits between the fractal renderer and the HDMI generator, in the pixel clock domain.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch
- H_SYNC, 40, hsync width
- H_BP, 220, horizontal back porch; must be >= 10 (preamble + guard)
- V_ACTIVE, 720, active lines
- V_FP, 5, vertical front porch lines
- V_SYNC, 5, vsync lines
- V_BP, 20, vertical back porch lines
- H_POL, 1, hsync active level
- V_POL, 1, vsync active level
- PIPE_LAT, 2, upstream pixel latency in cycles (1..8)
- CW, 12, coordinate counter width

Ports:
- i_pix_clk  in  1  pixel clock
- i_rst_n  in  1  asynchronous active-low reset
- i_en  in  1  run request; level-sensitive
- o_de  out  1  display enable to encoders
- o_ctrl_ch0  out  2  {vsync, hsync}
- o_ctrl_ch1  out  2  {CTL1, CTL0}
- o_ctrl_ch2  out  2  {CTL3, CTL2}
- o_guard  out  1  video guard band period; downstream muxes guard-band symbols
- o_req  out  1  pixel request for coordinate o_x/o_y
- o_x  out  CW  requested pixel column
- o_y  out  CW  requested pixel row
- o_frame_start  out  1  one-cycle pulse at main position (0,0)
- o_busy  out  1  high in RUN or DRAIN

Behaviour:
- H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP; V_TOTAL is formed likewise.
- Main counter (h,v) drives all timing outputs. Lead counter (hl,vl) equals main advanced by PIPE_LAT pixels, wrapping through h and v.
- Counters wrap: h at H_TOTAL-1 -> 0 with v+1; v at V_TOTAL-1 -> 0.
- All outputs are registered and decode the current counter values with one fixed cycle of register delay, applied equally to all outputs.
- o_de = (h < H_ACTIVE) && (v < V_ACTIVE).
- hsync is at H_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; otherwise at !H_POL.
- vsync is at V_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for whole lines; otherwise at !V_POL.
- "Next line active" (nla) is true when v < V_ACTIVE-1 or v == V_TOTAL-1.
- Preamble: h in [H_TOTAL-10, H_TOTAL-3] and nla -> o_ctrl_ch1=2'b01, o_ctrl_ch2=2'b00. At all other times both are 2'b00.
- Guard: h in [H_TOTAL-2, H_TOTAL-1] and nla -> o_guard=1. o_de stays 0 during guard.
- o_req = (hl < H_ACTIVE) && (vl < V_ACTIVE). When o_req=1, o_x=hl and o_y=vl; otherwise o_x/o_y hold their last values.
- Upstream pixel data is sampled with PIPE_LAT cycles of delay, so the requested pixel coincides with the o_de cycle.
- o_frame_start pulses when h==0 and v==0.
- FSM states:
  - IDLE: main counter held at (0, V_ACTIVE), lead counter at (PIPE_LAT, V_ACTIVE). All outputs at blanking values (de/req/guard 0, syncs inactive, ctrl 0). o_busy=0.
  - IDLE -> RUN when i_en=1. Counting starts on the next cycle. The first frame begins inside vertical blanking, so no partial active frame is ever emitted.
  - RUN -> DRAIN when i_en=0 is sampled.
  - DRAIN: counting continues. Leaves at h==H_TOTAL-1, v==V_ACTIVE-1, i.e. after the last active line. Goes to RUN if i_en=1 at that point, else to IDLE. This guarantees every started active frame completes.
  - i_en=1 seen in DRAIN before the exit point -> return to RUN with no counter disturbance.
- Asynchronous reset: outputs go immediately to IDLE values. o_ctrl_ch0={!V_POL,!H_POL}; o_x=o_y=0; o_frame_start=0; o_busy=0.
- Reset mid-line abandons the frame. No recovery beyond restart from IDLE.

Decomposition:
- Package hdmi_pkg holds:
  - FSM state enum {IDLE, RUN, DRAIN}
  - constants PREAMBLE_LEN=8, GUARD_LEN=2
  - CTL_VIDEO_PREAMBLE_CH1=2'b01, CTL_IDLE=2'b00
  - guard-band symbol constants for downstream use
- Sub-module video_pos_counter: wrapping h/v counter with synchronous load of a start position and an enable. Instantiated twice, once for main and once for lead.

Test Plan (small timing: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=12 -> H_TOTAL=33; V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 -> V_TOTAL=7; PIPE_LAT=2):
- Reset then i_en=1 held -> first o_frame_start after (7-4)*33=99 counted cycles. Each frame has exactly 4 DE runs of 16 cycles, and DE period is 33.
- Line timing -> hsync active for exactly 3 cycles starting 18 cycles after DE start. Preamble (ch1=01) for 8 cycles, then guard for 2 cycles, then DE rises immediately. No preamble/guard before the first vertical-blank line.
- Request alignment -> o_req rises exactly 2 cycles before o_de. o_x runs 0..15 and o_y 0..3; o_x=0, o_y=0 occurs 2 cycles before o_frame_start.
- i_en dropped at the start of active line 1 -> lines 1..3 still complete, then IDLE is entered with o_busy=0. Re-raising i_en yields a full frame with no partial lines.
- i_rst_n pulsed low mid-line -> outputs go asynchronously to blanking: de=0, req=0, ctrl_ch0=2'b00 (inverted polarity), guard=0.
- Toggle i_en low then high within the same active frame -> raster continues uninterrupted, with no missing or extra DE cycles.
